parallel_serial_param: RTL and testbench

Parametrised parallel-to-serial converter, successor to the fixed 8-bit `parallel_serial_cond`. It accepts WIDTH-bit words through a Valid/Ready handshake and serialises them one bit per clock with no gap between words. When no word is offered at a word boundary, it inserts a configurable idle symbol. It sits on the transmit side of the lane datapath and feeds the serial link and the matching serial-to-parallel receiver.

---
 rtl/parallel_serial_param.sv | 75 +++++++
 tb/tb_parallel_serial_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/parallel_serial_param.sv
// Parametrised parallel-to-serial converter: WIDTH-bit words in over Valid/Ready,
// one bit per clock out, idle symbol inserted when no word is offered at a boundary.
module parallel_serial_param #(
    parameter int unsigned WIDTH     = 8,
    parameter logic [7:0]  IDLE_SYM  = 8'hBC,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             Valid,
    output logic             Ready,
    output logic             DATA_OUT,
    output logic             DATA_VALID,
    output logic             SYNC
);

    localparam int unsigned     CntW     = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt  = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] IdleWord = WIDTH'(IDLE_SYM);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             wv_q, wv_d;
    logic             at_last;

    assign at_last = (cnt_q == LastCnt);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sh_q  <= '0;
            cnt_q <= LastCnt;
            wv_q  <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            wv_q  <= wv_d;
        end
    end

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        wv_d  = wv_q;
        if (EN) begin
            if (at_last) begin
                // Word boundary: always load, either the offered word or the idle symbol.
                cnt_d = '0;
                if (Valid) begin
                    sh_d = DATA_IN;
                    wv_d = 1'b1;
                end else begin
                    sh_d = IdleWord;
                    wv_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (MSB_FIRST) begin
                    sh_d = {sh_q[WIDTH-2:0], 1'b0};
                end else begin
                    sh_d = {1'b0, sh_q[WIDTH-1:1]};
                end
            end
        end
    end

    always_comb begin
        Ready      = RESET & EN & at_last;
        DATA_OUT   = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
        DATA_VALID = wv_q;
        SYNC       = (cnt_q == '0) & RESET;
    end

endmodule

// File: tb/tb_parallel_serial_param.sv
// Scoreboard bench: stimulus queues expected serial bits per accepted word, monitors
// pop and compare whenever a DUT presents a new bit, and check held bits while EN=0.
module tb_parallel_serial_param;

    typedef logic [2:0] rec_t;  // {DATA_OUT, DATA_VALID, SYNC}

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, en_a = 1'b1, valid_a = 1'b0;
    logic [7:0] data_a = '0;
    logic       ready_a, dout_a, dv_a, sync_a;
    logic       rst_b = 1'b0, en_b = 1'b1, valid_b = 1'b0;
    logic [9:0] data_b = '0;
    logic       ready_b, dout_b, dv_b, sync_b;

    int   checks = 0;
    int   errors = 0;
    rec_t q_a[$];
    rec_t q_b[$];
    rec_t last_a = '0, last_b = '0;
    logic adv_a = 1'b0, hold_a = 1'b0, adv_b = 1'b0, hold_b = 1'b0;

    always #5 clk = ~clk;

    parallel_serial_param dut_a (
        .CLK       (clk),
        .RESET     (rst_a),
        .EN        (en_a),
        .DATA_IN   (data_a),
        .Valid     (valid_a),
        .Ready     (ready_a),
        .DATA_OUT  (dout_a),
        .DATA_VALID(dv_a),
        .SYNC      (sync_a)
    );

    parallel_serial_param #(
        .WIDTH    (10),
        .IDLE_SYM (8'hBC),
        .MSB_FIRST(1'b0)
    ) dut_b (
        .CLK       (clk),
        .RESET     (rst_b),
        .EN        (en_b),
        .DATA_IN   (data_b),
        .Valid     (valid_b),
        .Ready     (ready_b),
        .DATA_OUT  (dout_b),
        .DATA_VALID(dv_b),
        .SYNC      (sync_b)
    );

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    // Edge classification: a new bit appears after an enabled edge; EN=0 edges hold it.
    always @(posedge clk) begin
        adv_a  <= rst_a & en_a;
        hold_a <= rst_a & ~en_a;
        adv_b  <= rst_b & en_b;
        hold_b <= rst_b & ~en_b;
    end

    always @(negedge clk) begin
        if (adv_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_bit", {29'd0, dout_a, dv_a, sync_a}, 32'hFFFF_FFFF);
            end else begin
                last_a = q_a.pop_front();
                chk("a_bit", {29'd0, dout_a, dv_a, sync_a}, {29'd0, last_a});
            end
        end else if (hold_a) begin
            chk("a_held_bit", {29'd0, dout_a, dv_a, sync_a}, {29'd0, last_a});
        end
    end

    always @(negedge clk) begin
        if (adv_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_bit", {29'd0, dout_b, dv_b, sync_b}, 32'hFFFF_FFFF);
            end else begin
                last_b = q_b.pop_front();
                chk("b_bit", {29'd0, dout_b, dv_b, sync_b}, {29'd0, last_b});
            end
        end else if (hold_b) begin
            chk("b_held_bit", {29'd0, dout_b, dv_b, sync_b}, {29'd0, last_b});
        end
    end

    function automatic logic rdy(input bit b);
        return b ? ready_b : ready_a;
    endfunction

    task automatic wait_ready(input bit b, input int exp_n, input string name);
        int n = 0;
        while (!rdy(b) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready_wait"}, n, exp_n);
    endtask

    // seq lists the bits in transmit order, first bit in the leftmost position.
    task automatic accept(input bit b, input logic v, input logic [9:0] d,
                          input logic [9:0] seq, input int exp_n, input string name);
        int w = b ? 10 : 8;
        if (b) begin
            valid_b = v;
            data_b  = d;
        end else begin
            valid_a = v;
            data_a  = d[7:0];
        end
        wait_ready(b, exp_n, name);
        for (int i = w - 1; i >= 0; i--) begin
            if (b) q_b.push_back({seq[i], v, i == w - 1});
            else   q_a.push_back({seq[i], v, i == w - 1});
        end
        @(negedge clk);
        if (b) valid_b = 1'b0;
        else   valid_a = 1'b0;
    endtask

    task automatic final_stop(input bit b, input int exp_n, input string name);
        wait_ready(b, exp_n, name);
        if (b) rst_b = 1'b0;
        else   rst_a = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_queue_drained"}, b ? q_b.size() : q_a.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("a_reset_outputs", {28'd0, dout_a, dv_a, sync_a, ready_a}, 32'd0);
        rst_a = 1'b1;
        #1;
        chk("a_ready_after_release", {31'd0, ready_a}, 32'd1);

        accept(1'b0, 1'b1, 10'h0A5, 10'b0010100101, 0, "a5_first");
        accept(1'b0, 1'b0, 10'h000, 10'b0010111100, 7, "idle");
        accept(1'b0, 1'b1, 10'h001, 10'b0000000001, 7, "b2b_01");
        accept(1'b0, 1'b1, 10'h0FF, 10'b0011111111, 7, "b2b_ff");

        // Freeze the serialiser for 2 cycles while bit 3 of 8'hA5 is on the line.
        accept(1'b0, 1'b1, 10'h0A5, 10'b0010100101, 7, "a5_hold");
        repeat (4) @(negedge clk);
        en_a = 1'b0;
        chk("hold_ready_low_0", {31'd0, ready_a}, 32'd0);
        @(negedge clk);
        chk("hold_ready_low_1", {31'd0, ready_a}, 32'd0);
        @(negedge clk);
        en_a = 1'b1;
        accept(1'b0, 1'b0, 10'h000, 10'b0010111100, 3, "after_hold");

        // Reset for one cycle while bit 4 of a word is on the line.
        accept(1'b0, 1'b1, 10'h0A5, 10'b0010100101, 7, "a5_reset");
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        q_a.delete();
        @(negedge clk);
        chk("mid_reset_outputs", {28'd0, dout_a, dv_a, sync_a, ready_a}, 32'd0);
        rst_a = 1'b1;
        #1;
        chk("mid_reset_ready_release", {31'd0, ready_a}, 32'd1);
        accept(1'b0, 1'b1, 10'h03C, 10'b0000111100, 0, "after_reset_3c");
        final_stop(1'b0, 7, "a_end");

        // WIDTH=10, LSB first; idle symbol zero-extended to 10'h0BC.
        @(negedge clk);
        chk("b_reset_outputs", {28'd0, dout_b, dv_b, sync_b, ready_b}, 32'd0);
        rst_b = 1'b1;
        #1;
        chk("b_ready_after_release", {31'd0, ready_b}, 32'd1);
        accept(1'b1, 1'b1, 10'h2A5, 10'b1010010101, 0, "b_2a5");
        accept(1'b1, 1'b0, 10'h000, 10'b0011110100, 9, "b_idle");
        final_stop(1'b1, 9, "b_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
